rr_arbiter_n: RTL and testbench
===============================

RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter N_MASTERS, default 4: number of requesting masters; the legal range is 2..16.
REQ-002 Parameter DATA_W, default 32: payload width per master.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles to wait for s_ack; 0 disables the timeout.
REQ-004 Parameter PRIO_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 Local SEL_W SHALL equal clog2(N_MASTERS).
REQ-006 clk_arb  in  1  the single clock; all logic is on the rising edge.
REQ-007 rst  in  1  reset; synchronous, active-high.
REQ-008 m_req  in  N_MASTERS  per-master request level.
REQ-009 m_data  in  N_MASTERS*DATA_W  flattened payloads; master i occupies bits [i*DATA_W +: DATA_W].
REQ-010 m_ack  out  N_MASTERS  one-cycle completion pulse per master.
REQ-011 m_err  out  N_MASTERS  one-cycle timeout-abort pulse per master.
REQ-012 s_req  out  1  request to the slave.
REQ-013 s_data  out  DATA_W  payload of the granted master.
REQ-014 s_sel  out  SEL_W  index of the granted master.
REQ-015 s_ack  in  1  slave completion strobe.
REQ-016 busy  out  1  high while a transaction is outstanding (state REQ).

Function
REQ-017 The FSM SHALL have two states: IDLE and REQ.
REQ-018 In IDLE with any m_req bit set, the winner SHALL be chosen in a single cycle:
  - Round-robin mode: first set bit at or after ptr, searching cyclically; idle masters are skipped with no lost cycles.
  - Fixed-priority mode: lowest set index.
REQ-019 Grant latency: m_req sampled high in IDLE at edge t SHALL produce, at edge t+1, s_req=1, busy=1, s_sel=winner, s_data=m_data[winner], and timer=0.
REQ-020 s_data and s_sel SHALL hold stable while s_req=1; m_data changes during REQ SHALL be ignored.
REQ-021 In REQ with s_ack=1, the next edge SHALL give: s_req=0, busy=0, m_ack[g]=1 for exactly one cycle, ptr=(g+1) mod N_MASTERS, state IDLE.
REQ-022 The ptr wrap from N_MASTERS-1 SHALL go to 0.
REQ-023 In fixed-priority mode, ptr SHALL be maintained but SHALL NOT affect selection.
REQ-024 The earliest next grant SHALL be issued by the edge after the return to IDLE; there is no arbitration in the ack cycle, so the minimum grant spacing is 2 cycles.
REQ-025 In REQ with s_ack=0, the timer SHALL increment, saturating at TIMEOUT.
REQ-026 When TIMEOUT>0, timer==TIMEOUT-1 and s_ack=0, the next edge SHALL give: s_req=0, m_err[g]=1 for one cycle, no m_ack, ptr advanced as in REQ-021, state IDLE.
REQ-027 s_ack in the timeout cycle SHALL take precedence: ack response, no m_err.
REQ-028 A master deasserting m_req during REQ SHALL NOT abort the transaction.
REQ-029 s_ack while IDLE SHALL be ignored, with no output change.
REQ-030 At most one bit of m_ack|m_err SHALL be high in any cycle.
REQ-031 s_req SHALL never be high in the same cycle as an m_ack or m_err pulse.

Reset
REQ-032 rst sampled high SHALL set, at that edge: state IDLE, ptr=0, timer=0, s_req=0, busy=0, m_ack=0, m_err=0, s_sel=0, s_data=0.
REQ-033 rst mid-transaction SHALL generate no m_ack or m_err for the aborted grant.
REQ-034 rst SHALL override s_ack and the timeout in the same cycle.

Verification (N_MASTERS=4, DATA_W=32, TIMEOUT=8, PRIO_MODE=0 unless stated)
REQ-035 Skip test: m_req=4'b1000 after reset -> s_req=1 with s_sel=3 one cycle later; s_ack -> m_ack=4'b1000 pulse; ptr=0 (wrap).
REQ-036 Fairness test: m_req=4'b1111 held, s_ack returned 1 cycle after each s_req -> s_sel sequence 0,1,2,3,0; s_data equals 32'hA0+i for m_data[i]=32'hA0+i.
REQ-037 Timeout test: grant master 2, hold s_ack=0 -> s_req falls after 8 REQ cycles; m_err=4'b0100 for one cycle; m_ack stays 0; next grant goes to master 3 if it is requesting.
REQ-038 Timeout/ack race: s_ack=1 in the 8th REQ cycle -> m_ack pulse only, no m_err.
REQ-039 Priority mode: PRIO_MODE=1, m_req=4'b1010 held -> s_sel=1 on every grant; master 3 is never served.
REQ-040 Reset mid-op: rst=1 while s_req=1 -> s_req=0, busy=0 next edge; no m_ack/m_err; first grant after reset starts the search at index 0.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-master arbiter onto a single request/ack slave port
// Round-robin or fixed-priority selection, one outstanding transaction, optional ack timeout.
module rr_arbiter_n #(
    parameter int N_MASTERS = 4,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 255,
    parameter int PRIO_MODE = 0,
    localparam int SEL_W    = $clog2(N_MASTERS)
) (
    input  logic                          clk_arb,
    input  logic                          rst,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS*DATA_W-1:0]   m_data,
    output logic [N_MASTERS-1:0]          m_ack,
    output logic [N_MASTERS-1:0]          m_err,
    output logic                          s_req,
    output logic [DATA_W-1:0]             s_data,
    output logic [SEL_W-1:0]              s_sel,
    input  logic                          s_ack,
    output logic                          busy
);

    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMO_SAT  = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_ptr;
    logic [TMR_W-1:0]     r_timer;
    logic                 r_s_req;
    logic                 r_busy;
    logic [SEL_W-1:0]     r_sel;
    logic [DATA_W-1:0]    r_data;
    logic [N_MASTERS-1:0] r_m_ack;
    logic [N_MASTERS-1:0] r_m_err;

    logic [N_MASTERS-1:0] w_ge_mask;
    logic [N_MASTERS-1:0] w_masked;
    logic [SEL_W-1:0]     w_winner;
    logic [SEL_W-1:0]     w_next_ptr;
    logic [N_MASTERS-1:0] w_grant_1h;
    logic                 w_timeout;

    function automatic logic [SEL_W-1:0] f_lowest(input logic [N_MASTERS-1:0] v);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (v[i]) idx = SEL_W'(i);
        end
        return idx;
    endfunction

    // Requests at or above ptr win first; if none, wrap to the lowest requester.
    always_comb begin
        w_ge_mask = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            w_ge_mask[i] = (i >= int'(r_ptr));
        end
        w_masked = m_req & w_ge_mask;
        if (PRIO_MODE != 0) begin
            w_winner = f_lowest(m_req);
        end else if (|w_masked) begin
            w_winner = f_lowest(w_masked);
        end else begin
            w_winner = f_lowest(m_req);
        end
    end

    assign w_next_ptr = (int'(r_sel) == N_MASTERS - 1) ? '0 : r_sel + 1'b1;
    assign w_grant_1h = {{(N_MASTERS-1){1'b0}}, 1'b1} << r_sel;
    assign w_timeout  = (TIMEOUT > 0) && (r_timer == TMO_LAST);

    always_ff @(posedge clk_arb) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_timer <= '0;
            r_s_req <= 1'b0;
            r_busy  <= 1'b0;
            r_sel   <= '0;
            r_data  <= '0;
            r_m_ack <= '0;
            r_m_err <= '0;
        end else begin
            r_m_ack <= '0;
            r_m_err <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|m_req) begin
                        r_state <= ST_REQ;
                        r_s_req <= 1'b1;
                        r_busy  <= 1'b1;
                        r_sel   <= w_winner;
                        r_data  <= m_data[int'(w_winner)*DATA_W +: DATA_W];
                        r_timer <= '0;
                    end
                end
                ST_REQ: begin
                    // Ack wins over a timeout landing in the same cycle.
                    if (s_ack || w_timeout) begin
                        r_state <= ST_IDLE;
                        r_s_req <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_next_ptr;
                        r_timer <= '0;
                        if (s_ack) begin
                            r_m_ack <= w_grant_1h;
                        end else begin
                            r_m_err <= w_grant_1h;
                        end
                    end else if (r_timer != TMO_SAT) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign m_ack  = r_m_ack;
    assign m_err  = r_m_err;
    assign s_req  = r_s_req;
    assign s_data = r_data;
    assign s_sel  = r_sel;
    assign busy   = r_busy;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - self-checking bench for rr_arbiter_n
module tb_rr_arbiter_n;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk_arb = 1'b0;
    always #5 clk_arb = ~clk_arb;

    logic          rst = 1'b1;
    logic [N-1:0]  m_req = '0;
    logic [N*DW-1:0] m_data = '0;
    logic          s_ack = 1'b0;
    logic [N-1:0]  m_ack, m_err;
    logic          s_req, busy;
    logic [DW-1:0] s_data;
    logic [1:0]    s_sel;

    logic          rst_b = 1'b1;
    logic [N-1:0]  m_req_b = '0;
    logic          s_ack_b = 1'b0;
    logic [N-1:0]  m_ack_b, m_err_b;
    logic          s_req_b, busy_b;
    logic [DW-1:0] s_data_b;
    logic [1:0]    s_sel_b;

    rr_arbiter_n #(.N_MASTERS(N), .DATA_W(DW), .TIMEOUT(TO), .PRIO_MODE(0)) dut (
        .clk_arb(clk_arb), .rst(rst), .m_req(m_req), .m_data(m_data),
        .m_ack(m_ack), .m_err(m_err), .s_req(s_req), .s_data(s_data),
        .s_sel(s_sel), .s_ack(s_ack), .busy(busy)
    );

    rr_arbiter_n #(.N_MASTERS(N), .DATA_W(DW), .TIMEOUT(TO), .PRIO_MODE(1)) dut_prio (
        .clk_arb(clk_arb), .rst(rst_b), .m_req(m_req_b), .m_data(m_data),
        .m_ack(m_ack_b), .m_err(m_err_b), .s_req(s_req_b), .s_data(s_data_b),
        .s_sel(s_sel_b), .s_ack(s_ack_b), .busy(busy_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding grant, a wait counter and a fairness pointer.
    bit            md_busy = 0;
    int            md_g    = 0;
    int            md_ptr  = 0;
    int            md_wait = 0;
    logic [1:0]    md_sel  = '0;
    logic [DW-1:0] md_sdata = '0;
    logic [N-1:0]  md_ack  = '0;
    logic [N-1:0]  md_err  = '0;

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic model_update();
        md_ack = '0;
        md_err = '0;
        if (rst) begin
            md_busy = 0; md_ptr = 0; md_wait = 0; md_sel = '0; md_sdata = '0;
        end else if (md_busy) begin
            if (s_ack || md_wait == TO - 1) begin
                if (s_ack) md_ack[md_g] = 1'b1;
                else       md_err[md_g] = 1'b1;
                md_busy = 0;
                md_ptr  = (md_g + 1) % N;
                md_wait = 0;
            end else begin
                md_wait++;
            end
        end else if (m_req != '0) begin
            md_g     = pick(m_req, md_ptr);
            md_busy  = 1;
            md_sel   = 2'(md_g);
            md_sdata = m_data[md_g*DW +: DW];
            md_wait  = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk_arb);
        model_update();
        #1;
        chk("mdl_s_req", s_req, md_busy);
        chk("mdl_busy", busy, md_busy);
        chk("mdl_s_sel", s_sel, md_sel);
        chk("mdl_s_data", s_data, md_sdata);
        chk("mdl_m_ack", m_ack, md_ack);
        chk("mdl_m_err", m_err, md_err);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       ack;
        logic       exp_sreq;
        logic [1:0] exp_sel;
        logic [3:0] exp_mack;
        logic [3:0] exp_merr;
    } vec_t;

    vec_t tbl[15];
    int   grants;

    initial begin
        tbl[0]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[1]  = '{1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000};
        tbl[2]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b1000, 4'b0000};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000};
        tbl[5]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0010, 4'b0000};
        tbl[7]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0100, 4'b0000};
        tbl[9]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000};
        tbl[10] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b1000, 4'b0000};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000};
        tbl[12] = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 4'b0001, 4'b0000};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0000};

        for (int i = 0; i < N; i++) m_data[i*DW +: DW] = 32'hA0 + i;

        // Skip, wrap and fairness vectors
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst; m_req = tbl[i].req; s_ack = tbl[i].ack;
            tick();
            chk("tbl_s_req", s_req, tbl[i].exp_sreq);
            chk("tbl_busy", busy, tbl[i].exp_sreq);
            chk("tbl_m_ack", m_ack, tbl[i].exp_mack);
            chk("tbl_m_err", m_err, tbl[i].exp_merr);
            if (tbl[i].exp_sreq) begin
                chk("tbl_s_sel", s_sel, tbl[i].exp_sel);
                chk("tbl_s_data", s_data, 32'hA0 + tbl[i].exp_sel);
            end
            if (tbl[i].rst) begin
                chk("rst_s_sel", s_sel, 0);
                chk("rst_s_data", s_data, 0);
            end
        end

        // Timeout on master 2, master 3 waiting
        m_req = 4'b0100; s_ack = 1'b0;
        tick();
        chk("to_grant_sel", s_sel, 2);
        m_req = 4'b1100;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("to_hold_sreq", s_req, 1);
            chk("to_hold_merr", m_err, 0);
        end
        tick();
        chk("to_sreq", s_req, 0);
        chk("to_merr", m_err, 4'b0100);
        chk("to_mack", m_ack, 0);
        tick();
        chk("to_next_sel", s_sel, 3);
        chk("to_next_sreq", s_req, 1);
        chk("to_pulse_len", m_err, 0);

        // Ack in the last timeout cycle
        for (int k = 1; k <= 7; k++) tick();
        s_ack = 1'b1; m_req = 4'b0000;
        tick();
        chk("race_mack", m_ack, 4'b1000);
        chk("race_merr", m_err, 0);
        chk("race_sreq", s_req, 0);
        s_ack = 1'b0;

        // Reset mid-transaction with ptr parked away from 0
        m_req = 4'b0010;
        tick();
        chk("rm_sel1", s_sel, 1);
        s_ack = 1'b1; m_req = 4'b0000;
        tick();
        chk("rm_ack1", m_ack, 4'b0010);
        s_ack = 1'b0; m_req = 4'b0100;
        tick();
        chk("rm_sel2", s_sel, 2);
        rst = 1'b1; s_ack = 1'b1;
        tick();
        chk("rm_sreq", s_req, 0);
        chk("rm_busy", busy, 0);
        chk("rm_mack", m_ack, 0);
        chk("rm_merr", m_err, 0);
        rst = 1'b0; s_ack = 1'b0; m_req = 4'b1110;
        tick();
        chk("rm_first_sel", s_sel, 1);
        s_ack = 1'b1; m_req = 4'b0000;
        tick();
        s_ack = 1'b0;

        // Randomized traffic against the model
        for (int blk = 0; blk < 15; blk++) begin
            int ack_th;
            ack_th = $urandom_range(0, 5);
            for (int c = 0; c < 100; c++) begin
                rst    = ($urandom_range(0, 63) == 0);
                m_req  = 4'($urandom_range(0, 15));
                s_ack  = ($urandom_range(0, 9) < ack_th);
                m_data = {$urandom, $urandom, $urandom, $urandom};
                tick();
                chk("inv_onehot", $countones(m_ack | m_err) <= 1, 1);
                chk("inv_sreq_pulse", s_req && (|(m_ack | m_err)), 0);
            end
        end
        rst = 1'b1; m_req = '0; s_ack = 1'b0;
        for (int i = 0; i < N; i++) m_data[i*DW +: DW] = 32'hA0 + i;
        tick();

        // Fixed-priority instance
        chk("prio_rst_sreq", s_req_b, 0);
        chk("prio_rst_sel", s_sel_b, 0);
        chk("prio_rst_data", s_data_b, 0);
        rst_b = 1'b0; m_req_b = 4'b1010; s_ack_b = 1'b0;
        grants = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (s_req_b) begin
                grants++;
                chk("prio_sel", s_sel_b, 1);
                chk("prio_data", s_data_b, 32'hA1);
            end
            chk("prio_m3_unserved", m_ack_b[3] | m_err_b[3], 0);
            s_ack_b = s_req_b;
        end
        chk("prio_grants", grants, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
